descrambler_block_ctrl: RTL and testbench
=========================================

// Module: descrambler_block_ctrl
// PURPOSE
//  Receive-side 128b/130b block sequencer driving the descrambler LFSR bank and byte XOR masks.
//  Tracks 16-symbol block boundaries from PIPE start-block/sync-header and classifies each block (data, OS, SKP, EIEOS).
//  Emits per-byte advance, bypass, LFSR width select and pattern reset.
//  Sits between the PIPE RX interface and the descrambler datapath, one instance per lane.
// PARAMETERS
//  BLK_SYMS     16   symbols per 128b block
//  SYM_EIEOS    8'h00 first symbol of EIEOS block; pattern 00,FF repeating
//  SYM_SKP      8'hAA  SKP OS symbol
//  SYM_SKP_END  8'hE1  SKP_END symbol; 3 LFSR-snapshot symbols follow
// PORTS
//  clk              in   1   PIPE clock
//  reset            in   1   async, active-high
//  turnOff          in   1   descrambling disabled; all outputs idle, state held in HUNT
//  PIPEDataValid    in   1   current beat valid
//  PIPEStartBlock   in   1   beat carries symbol 0 of a block
//  PIPESyncHeader   in   2   2'b10 data block, 2'b01 OS block; sampled only with PIPEStartBlock
//  PIPEWIDTH        in   6   8/16/32 bits per beat
//  PIPEData         in   32  current beat, byte 0 = earliest symbol
//  patternReset     out  1   reload all LFSRs with seed at next clk
//  advance          out  4   byte i consumes an LFSR byte (XOR applied)
//  bypass           out  4   byte i passes unscrambled
//  lfsrSel          out  2   0: 8b, 1: 16b, 2: 32b LFSR
//  blockType        out  2   0 data, 1 OS, 2 SKP, 3 EIEOS (current block)
//  syncErr          out  1   one-cycle pulse on framing or header error
//  locked           out  1   block alignment acquired
// BEHAVIOUR
//  Reset: state HUNT, symCnt=0, blockType=0, locked=0; all outputs 0 except bypass=4'hF.
//  bytesPerBeat = PIPEWIDTH/8. lfsrSel = 0/1/2 for 8/16/32.
//  Other PIPEWIDTH values: advance=0, bypass=F, syncErr pulse; state held.
//  Outputs are combinational from registered state plus the current beat (zero latency).
//  State updates on clk rising edge only when PIPEDataValid=1. Invalid beats: advance=0 and bypass=F.
//  States:
//   HUNT   -> BLOCK on PIPEStartBlock with a legal header; else stay. locked=0.
//   BLOCK  symCnt += bytesPerBeat (mod BLK_SYMS).
//          On wrap to 0, the next valid beat must carry PIPEStartBlock; otherwise syncErr and go to HUNT.
//          PIPEStartBlock with symCnt!=0: syncErr, restart block at this beat (stay BLOCK).
//          Illegal header (00/11): syncErr -> HUNT.
//  Classification happens at symbol 0 and is held for the block:
//   header 10 -> data; header 01 with byte0 SYM_EIEOS -> EIEOS; byte0 SYM_SKP -> SKP; other -> OS.
//  Per byte i < bytesPerBeat, by block type:
//   data: advance=1, bypass=0.
//   OS: symbol 0 has bypass=1, advance=1; other symbols have advance=1, bypass=0.
//   SKP: advance=0, bypass=1 for the whole block.
//   EIEOS: advance=0, bypass=1 for the whole block.
//  Bytes with i >= bytesPerBeat: advance=0, bypass=1.
//  patternReset: asserted during the last beat of an EIEOS block (symCnt wraps).
//  EIEOS block shorter than BLK_SYMS (early start): no patternReset, syncErr.
//  SKP_END in an SKP block ends the block after 3 further symbols. Next start is expected at that point; symCnt is reset.
//  turnOff=1: outputs idle; state forced to HUNT at next clk. Deassertion requires reacquisition.
//  locked: 1 in BLOCK after the first complete error-free block; cleared on HUNT entry.
//  Simultaneous syncErr and EIEOS end: error wins, so no patternReset.
// CONFIGURATION
//  DESCR_ERR_CNT_EN defined: adds output errCnt[7:0], a saturating count of syncErr pulses.
//   errCnt is cleared by reset only.
//  DESCR_ERR_CNT_EN undefined: no counter and no port; syncErr only.
// STRUCTURE
//  Package descr_pkg: block-type enum, sync header constants, SYM_* values, state enum, width→lfsrSel function.
//  Sub-module descr_sym_counter: symCnt, wrap and early/late-start detection.
//  FSM and per-byte mask decode stay in the top.
// TESTING
//  W=32, start+hdr 10, 4 beats -> advance=F,bypass=0 each beat; locked=1 after block 1.
//  W=8, OS block byte0=1E (TS1) -> sym0 bypass=1/advance=1, syms1-15 advance=1.
//  W=16, EIEOS block (00,FF x8) -> advance=0 all; patternReset=1 only on beat 8.
//  W=32, SKP AA x8,E1,3 bytes,start -> advance=0, bypass=F; next start accepted, no syncErr.
//  W=32, start at symCnt=8 -> syncErr pulse, block restarts; hdr 11 -> HUNT, locked=0.
//  turnOff mid-block -> outputs idle next cycle, HUNT; with DESCR_ERR_CNT_EN, 300 errors -> errCnt=255.

Source files
------------

// File: rtl/descr_pkg.sv
// Shared constants, enums and helpers for the 128b/130b receive block sequencer.
package descr_pkg;

    localparam int         BLK_SYMS    = 16;
    localparam logic [7:0] SYM_EIEOS   = 8'h00;
    localparam logic [7:0] SYM_SKP     = 8'hAA;
    localparam logic [7:0] SYM_SKP_END = 8'hE1;

    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_OS   = 2'b01;

    typedef enum logic [1:0] {
        BT_DATA  = 2'd0,
        BT_OS    = 2'd1,
        BT_SKP   = 2'd2,
        BT_EIEOS = 2'd3
    } blk_type_e;

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_BLOCK = 1'b1
    } state_e;

    function automatic logic width_ok(input logic [5:0] w);
        return (w == 6'd8) || (w == 6'd16) || (w == 6'd32);
    endfunction

    // LFSR width select follows the beat width; unsupported widths fall back to 8b
    function automatic logic [1:0] width_to_sel(input logic [5:0] w);
        case (w)
            6'd16:   return 2'd1;
            6'd32:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] width_to_bytes(input logic [5:0] w);
        case (w)
            6'd8:    return 3'd1;
            6'd16:   return 3'd2;
            6'd32:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic blk_type_e classify(input logic [1:0] hdr, input logic [7:0] sym0);
        if (hdr == HDR_DATA)       return BT_DATA;
        else if (sym0 == SYM_EIEOS) return BT_EIEOS;
        else if (sym0 == SYM_SKP)   return BT_SKP;
        else                        return BT_OS;
    endfunction

endpackage

// File: rtl/descrambler_block_ctrl_if.sv
// PIPE RX beat in, descrambler control out. errCnt exists only when
// DESCR_ERR_CNT_EN is defined.
interface descrambler_block_ctrl_if;
    logic        PIPEDataValid;
    logic        PIPEStartBlock;
    logic [1:0]  PIPESyncHeader;
    logic [5:0]  PIPEWIDTH;
    logic [31:0] PIPEData;

    logic        patternReset;
    logic [3:0]  advance;
    logic [3:0]  bypass;
    logic [1:0]  lfsrSel;
    logic [1:0]  blockType;
    logic        syncErr;
    logic        locked;
`ifdef DESCR_ERR_CNT_EN
    logic [7:0]  errCnt;
`endif

    modport master (
        output PIPEDataValid, PIPEStartBlock, PIPESyncHeader, PIPEWIDTH, PIPEData,
        input  patternReset, advance, bypass, lfsrSel, blockType, syncErr, locked
`ifdef DESCR_ERR_CNT_EN
        , input errCnt
`endif
    );

    modport slave (
        input  PIPEDataValid, PIPEStartBlock, PIPESyncHeader, PIPEWIDTH, PIPEData,
        output patternReset, advance, bypass, lfsrSel, blockType, syncErr, locked
`ifdef DESCR_ERR_CNT_EN
        , output errCnt
`endif
    );
endinterface

// File: rtl/descr_sym_counter.sv
// Symbol position within the current 128b block, block-end (wrap) detection
// including the shortened SKP block, and early/missing start-of-block detection.
module descr_sym_counter
    import descr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_start,
    input  logic [2:0] i_bpb,
    input  logic       i_skpHit,
    input  logic [1:0] i_skpPos,
    output logic       o_wrap,
    output logic       o_early,
    output logic       o_missed
);
    localparam logic [4:0] END_FULL = 5'(BLK_SYMS);

    logic [3:0] r_symCnt;
    logic [4:0] r_endAt;
    logic [4:0] w_base;
    logic [4:0] w_endAt;
    logic [4:0] w_sum;

    // A start beat always sits at symbol 0; the first SKP_END pulls the block end to 3 symbols past it
    always_comb begin
        w_base  = i_start ? '0 : {1'b0, r_symCnt};
        w_endAt = i_start ? END_FULL : r_endAt;
        if (i_skpHit && (i_start || r_endAt == END_FULL))
            w_endAt = w_base + {3'b000, i_skpPos} + 5'd4;
        w_sum = w_base + {2'b00, i_bpb};
    end

    assign o_wrap   = w_sum >= w_endAt;
    assign o_early  = i_start && (r_symCnt != 4'd0);
    assign o_missed = !i_start && (r_symCnt == 4'd0);

    // Advance position on accepted beats; a completed block returns to symbol 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_symCnt <= '0;
            r_endAt  <= END_FULL;
        end else if (i_clear) begin
            r_symCnt <= '0;
            r_endAt  <= END_FULL;
        end else if (i_en) begin
            if (o_wrap) begin
                r_symCnt <= '0;
                r_endAt  <= END_FULL;
            end else begin
                r_symCnt <= w_sum[3:0];
                r_endAt  <= w_endAt;
            end
        end
    end
endmodule

// File: rtl/descrambler_block_ctrl.sv
// Receive-side 128b/130b block sequencer, one per lane. Tracks block alignment
// from PIPE start-block/sync-header, classifies blocks and drives the per-byte
// descrambler advance/bypass masks with zero latency.
// Optional: define DESCR_ERR_CNT_EN for a saturating syncErr counter (errCnt).
module descrambler_block_ctrl
    import descr_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    turnOff,
    descrambler_block_ctrl_if.slave bus
);
    state_e     r_state;
    blk_type_e  r_blkType;
    logic       r_locked;

    logic       w_idle, w_widthOk, w_beat, w_start, w_hdrLegal, w_badHdr;
    logic [2:0] w_bpb;
    logic [3:0] w_bmask;
    blk_type_e  w_curType, w_type;
    logic       w_wrap, w_early, w_missed, w_act, w_goHunt, w_syncErr;
    logic       w_skpHit;
    logic [1:0] w_skpPos;

    assign w_idle     = reset | turnOff;
    assign w_widthOk  = width_ok(bus.PIPEWIDTH);
    assign w_bpb      = width_to_bytes(bus.PIPEWIDTH);
    assign w_beat     = bus.PIPEDataValid & ~w_idle & w_widthOk;
    assign w_start    = bus.PIPEStartBlock;
    assign w_hdrLegal = (bus.PIPESyncHeader == HDR_DATA) || (bus.PIPESyncHeader == HDR_OS);
    assign w_badHdr   = w_start & ~w_hdrLegal;
    assign w_curType  = classify(bus.PIPESyncHeader, bus.PIPEData[7:0]);
    assign w_type     = w_start ? w_curType : r_blkType;

    // Bytes of the beat that carry symbols at the current width
    always_comb begin
        case (w_bpb)
            3'd1:    w_bmask = 4'b0001;
            3'd2:    w_bmask = 4'b0011;
            3'd4:    w_bmask = 4'b1111;
            default: w_bmask = 4'b0000;
        endcase
    end

    // Lowest-numbered SKP_END byte in an SKP block
    always_comb begin
        w_skpHit = 1'b0;
        w_skpPos = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_skpHit && w_bmask[i] && bus.PIPEData[8*i +: 8] == SYM_SKP_END) begin
                w_skpHit = 1'b1;
                w_skpPos = 2'(i);
            end
        end
        w_skpHit = w_skpHit & (w_type == BT_SKP);
    end

    assign w_act = (r_state == ST_HUNT) ? (w_beat & w_start & w_hdrLegal)
                                        : (w_beat & ~w_missed & ~w_badHdr);
    assign w_goHunt  = (r_state == ST_BLOCK) & w_beat & (w_missed | w_badHdr);
    assign w_syncErr = (bus.PIPEDataValid & ~w_idle & ~w_widthOk)
                     | ((r_state == ST_BLOCK) & w_beat & (w_missed | w_badHdr | w_early));

    descr_sym_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_goHunt | turnOff),
        .i_en     (w_act),
        .i_start  (w_start),
        .i_bpb    (w_bpb),
        .i_skpHit (w_skpHit),
        .i_skpPos (w_skpPos),
        .o_wrap   (w_wrap),
        .o_early  (w_early),
        .o_missed (w_missed)
    );

    // Alignment FSM: hunt for a legal start, hold block type, lock after a clean block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_HUNT;
            r_blkType <= BT_DATA;
            r_locked  <= 1'b0;
        end else if (turnOff || w_goHunt) begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
        end else if (w_act) begin
            r_state <= ST_BLOCK;
            if (w_start)
                r_blkType <= w_curType;
            if (w_wrap)
                r_locked <= 1'b1;
        end
    end

    // Per-byte descrambler masks for the current beat
    always_comb begin
        bus.advance = '0;
        bus.bypass  = '1;
        if (w_act) begin
            case (w_type)
                BT_DATA: begin
                    bus.advance = w_bmask;
                    bus.bypass  = ~w_bmask;
                end
                BT_OS: begin
                    bus.advance = w_bmask;
                    bus.bypass  = ~w_bmask | {3'b000, w_start};
                end
                default: ;
            endcase
        end
    end

    assign bus.patternReset = w_act & w_wrap & (w_type == BT_EIEOS) & ~w_syncErr;
    assign bus.syncErr      = w_syncErr;
    assign bus.lfsrSel      = w_idle ? 2'd0 : width_to_sel(bus.PIPEWIDTH);
    assign bus.blockType    = w_idle ? BT_DATA : ((w_act & w_start) ? w_curType : r_blkType);
    assign bus.locked       = r_locked & ~w_idle;

`ifdef DESCR_ERR_CNT_EN
    logic [7:0] r_errCnt;

    // Saturating count of syncErr pulses since reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_errCnt <= '0;
        else if (w_syncErr && r_errCnt != '1)
            r_errCnt <= r_errCnt + 8'd1;
    end

    assign bus.errCnt = r_errCnt;
`endif
endmodule

// File: tb/tb_descrambler_block_ctrl.sv
// Bench for descrambler_block_ctrl: directed scenarios then randomized block
// streams, each beat checked against a symbol-level reference model.
module tb_descrambler_block_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic turnOff;

    always #5 clk = ~clk;

    descrambler_block_ctrl_if bus ();

    descrambler_block_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .turnOff (turnOff),
        .bus     (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // reference model state
    bit         m_aligned = 0;
    int         m_pos     = 0;
    int         m_len     = 16;
    logic [1:0] m_type    = 2'd0;
    bit         m_locked  = 0;
    int         m_errs    = 0;

    localparam int K_DATA = 0, K_OS = 1, K_SKP = 2, K_EIEOS = 3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cls(input logic [1:0] hdr, input logic [7:0] b0);
        if (hdr == 2'b10) return 2'd0;
        if (b0 == 8'h00)  return 2'd3;
        if (b0 == 8'hAA)  return 2'd2;
        return 2'd1;
    endfunction

    // Drive one beat, check outputs against the model, let the clock consume it.
    task automatic step(input bit v, input bit st, input logic [1:0] hdr,
                        input logic [5:0] w, input logic [31:0] d);
        logic [3:0] e_adv, e_byp;
        logic [1:0] e_sel, e_bt;
        bit e_pr, e_se, e_lk, legal, newblk, cont, err;
        int n, e_cnt;
        @(negedge clk);
        bus.PIPEDataValid  = v;
        bus.PIPEStartBlock = st;
        bus.PIPESyncHeader = hdr;
        bus.PIPEWIDTH      = w;
        bus.PIPEData       = d;
        #1;
        e_adv = 4'h0; e_byp = 4'hF; e_pr = 0; e_se = 0; e_sel = 2'd0;
        e_bt = m_type; e_lk = m_locked;
        e_cnt = (m_errs > 255) ? 255 : m_errs;
        newblk = 0; cont = 0; err = 0; legal = 0;
        if (turnOff) begin
            e_bt = 2'd0; e_lk = 0;
            m_aligned = 0; m_locked = 0; m_pos = 0;
        end else begin
            n = int'(w) / 8;
            e_sel = (w == 6'd16) ? 2'd1 : (w == 6'd32) ? 2'd2 : 2'd0;
            if (v) begin
                if (!(w == 6'd8 || w == 6'd16 || w == 6'd32)) err = 1;
                else begin
                    legal = (hdr == 2'b10) || (hdr == 2'b01);
                    if (!m_aligned) newblk = st && legal;
                    else if ((!st && m_pos == 0) || (st && !legal)) begin
                        err = 1; m_aligned = 0; m_locked = 0; m_pos = 0;
                    end else if (st) begin
                        err = (m_pos != 0); newblk = 1;
                    end else cont = 1;
                end
            end
            if (newblk) begin
                m_aligned = 1; m_pos = 0; m_len = 16;
                m_type = cls(hdr, d[7:0]); e_bt = m_type; cont = 1;
            end
            if (cont) begin
                for (int i = 0; i < n; i++) begin
                    int p;
                    p = m_pos + i;
                    case (m_type)
                        2'd0: begin e_adv[i] = 1'b1; e_byp[i] = 1'b0; end
                        2'd1: begin e_adv[i] = 1'b1; e_byp[i] = (p == 0); end
                        2'd2: if (m_len == 16 && d[8*i +: 8] == 8'hE1) m_len = p + 4;
                        default: ;
                    endcase
                end
                m_pos += n;
                if (m_pos >= m_len) begin
                    m_pos = 0; m_locked = 1;
                    e_pr = (m_type == 2'd3) && !err;
                end
            end
            if (err) m_errs++;
            e_se = err;
        end
        chk("advance",      32'(bus.advance),      32'(e_adv));
        chk("bypass",       32'(bus.bypass),       32'(e_byp));
        chk("patternReset", 32'(bus.patternReset), 32'(e_pr));
        chk("syncErr",      32'(bus.syncErr),      32'(e_se));
        chk("lfsrSel",      32'(bus.lfsrSel),      32'(e_sel));
        chk("blockType",    32'(bus.blockType),    32'(e_bt));
        chk("locked",       32'(bus.locked),       32'(e_lk));
`ifdef DESCR_ERR_CNT_EN
        chk("errCnt",       32'(bus.errCnt),       32'(e_cnt));
`endif
        @(posedge clk);
        #1 bus.PIPEDataValid = 1'b0;
    endtask

    // Send one block of the given kind; cut>0 truncates it after that many symbols.
    task automatic send_block(input logic [5:0] w, input int kind, input int cut,
                              input int skpk, input logic [7:0] os0, input bit noise);
        logic [7:0]  s [16];
        logic [31:0] d;
        logic [1:0]  hdr;
        int len, n;
        n = int'(w) / 8;
        len = 16;
        hdr = (kind == K_DATA) ? 2'b10 : 2'b01;
        for (int i = 0; i < 16; i++) s[i] = 8'($urandom);
        case (kind)
            K_OS: s[0] = os0;
            K_EIEOS: for (int i = 0; i < 16; i++) s[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
            K_SKP: begin
                for (int i = 0; i < 4 * skpk; i++) s[i] = 8'hAA;
                s[4 * skpk] = 8'hE1;
                len = 4 * skpk + 4;
            end
            default: ;
        endcase
        for (int b = 0; b < len && (cut == 0 || b < cut); b += n) begin
            if (noise && $urandom_range(0, 7) == 0)
                step(1'b0, 1'($urandom), 2'($urandom), w, $urandom);
            d = $urandom;
            for (int i = 0; i < n; i++) d[8*i +: 8] = s[b + i];
            step(1'b1, b == 0, hdr, w, d);
        end
    endtask

    initial begin
        logic [5:0] w;
        logic [7:0] os0;
        int kind, n, len, cut, skpk;

        // reset state
        reset = 1'b1; turnOff = 1'b0;
        bus.PIPEDataValid = 1'b1; bus.PIPEStartBlock = 1'b1; bus.PIPESyncHeader = 2'b10;
        bus.PIPEWIDTH = 6'd32; bus.PIPEData = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_advance",      32'(bus.advance),      32'h0);
        chk("rst_bypass",       32'(bus.bypass),       32'hF);
        chk("rst_patternReset", 32'(bus.patternReset), 32'h0);
        chk("rst_syncErr",      32'(bus.syncErr),      32'h0);
        chk("rst_lfsrSel",      32'(bus.lfsrSel),      32'h0);
        chk("rst_blockType",    32'(bus.blockType),    32'h0);
        chk("rst_locked",       32'(bus.locked),       32'h0);
        bus.PIPEDataValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // W=32 data blocks, lock after the first
        send_block(6'd32, K_DATA, 0, 0, 8'h00, 0);
        chk("locked_after_blk1", 32'(bus.locked), 32'h1);
        send_block(6'd32, K_DATA, 0, 0, 8'h00, 0);
        // W=8 TS1 ordered set
        send_block(6'd8, K_OS, 0, 0, 8'h1E, 0);
        // W=16 EIEOS, patternReset on the 8th beat
        send_block(6'd16, K_EIEOS, 0, 0, 8'h00, 0);
        // W=32 SKP: AA x8, E1, 3 snapshot bytes, then a new start
        send_block(6'd32, K_SKP, 0, 2, 8'h00, 0);
        send_block(6'd32, K_DATA, 0, 0, 8'h00, 0);
        // early start at symCnt=8, then illegal header
        send_block(6'd32, K_DATA, 8, 0, 8'h00, 0);
        send_block(6'd32, K_DATA, 8, 0, 8'h00, 0);
        step(1'b1, 1'b1, 2'b11, 6'd32, $urandom);
        chk("locked_after_hdr11", 32'(bus.locked), 32'h0);
        // missing start after a complete block
        send_block(6'd16, K_DATA, 0, 0, 8'h00, 0);
        step(1'b1, 1'b0, 2'b10, 6'd16, $urandom);
        // unsupported width
        send_block(6'd32, K_OS, 8, 0, 8'h2D, 0);
        step(1'b1, 1'b0, 2'b10, 6'd24, $urandom);
        // EIEOS cut short: no patternReset, syncErr on the next start
        send_block(6'd16, K_EIEOS, 8, 0, 8'h00, 0);
        send_block(6'd16, K_DATA, 0, 0, 8'h00, 0);
        // turnOff mid-block, then reacquire
        send_block(6'd32, K_DATA, 8, 0, 8'h00, 0);
        turnOff = 1'b1;
        step(1'b1, 1'b0, 2'b10, 6'd32, $urandom);
        step(1'b1, 1'b1, 2'b10, 6'd32, $urandom);
        turnOff = 1'b0;
        step(1'b1, 1'b0, 2'b10, 6'd32, $urandom);
        send_block(6'd32, K_DATA, 0, 0, 8'h00, 0);

        // randomized block stream
        for (int blk = 0; blk < 150; blk++) begin
            case ($urandom_range(0, 2))
                0: w = 6'd8;
                1: w = 6'd16;
                default: w = 6'd32;
            endcase
            n = int'(w) / 8;
            kind = $urandom_range(0, 3);
            skpk = $urandom_range(1, 3);
            len = (kind == K_SKP) ? 4 * skpk + 4 : 16;
            cut = ($urandom_range(0, 9) == 0) ? n * $urandom_range(1, len / n - 1) : 0;
            os0 = 8'($urandom);
            if (os0 == 8'h00 || os0 == 8'hAA) os0 = 8'h1E;
            send_block(w, kind, cut, skpk, os0, 1);
            case ($urandom_range(0, 19))
                0: step(1'b1, 1'b0, 2'b10, w, $urandom);
                1: step(1'b1, 1'b0, 2'b10, 6'd12, $urandom);
                2: step(1'b1, 1'b1, 2'($urandom_range(0, 1) * 3), w, $urandom);
                default: ;
            endcase
        end

`ifdef DESCR_ERR_CNT_EN
        for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 2'b10, 6'd12, $urandom);
        chk("errCnt_saturated", 32'(bus.errCnt), 32'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
